// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-read-port register file.
//   clr_state_e      : sweep-clear FSM states (ST_IDLE, ST_CLEAR)
//   *_DEF            : default parameter values used by the interface and RTL
//   regfile_addr_ok  : range check, true when addr selects a real entry
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned NUM_RD_DEF = 2;

  // DEPTH need not be a power of two, so some encodable addresses are holes.
  function automatic logic regfile_addr_ok(input int unsigned addr,
                                           input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
// Bus bundle between a regfile client (master) and regfile_mp (slave).
//   reg_enable          : global enable for reads and writes
//   wr_en/addr/data     : single write port
//   rd_en/rd_addr       : NUM_RD read requests, port p at [p*ADDR_W +: ADDR_W]
//   rd_data/rd_valid    : registered read results, port p at [p*DATA_W +: DATA_W]
//   clr_req/busy        : sweep-clear request and in-progress flag
// -----------------------------------------------------------------------------
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                     reg_enable;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output reg_enable, wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  reg_enable, wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/regfile_clr_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_clr_ctrl
// Sweep-clear engine: on clr_req in IDLE, walks indices 0..DEPTH-1, one per
// cycle, then returns to IDLE. busy is high for exactly DEPTH cycles.
//   clk, rst   : clock, synchronous active-high reset (aborts a sweep)
//   clr_req    : start pulse, ignored while a sweep runs
//   busy       : sweep in progress
//   clr_en     : entry clr_idx is zeroed at the next edge
//   clr_idx    : entry being zeroed
// -----------------------------------------------------------------------------
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign clr_en  = busy;
  assign clr_idx = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with one write port, registered reads
// (latency 1), per-port read-valid, optional hardwired-zero entry 0 and a
// sequential sweep clear.
//   clk, rst : clock, synchronous active-high reset (clears every entry)
//   bus      : regfile_if.slave (enable, write port, read ports, clear)
// Build option: define REGFILE_BYPASS_EN for write-first forwarding of a
// same-cycle write to matching read ports; otherwise reads are read-first.
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned NUM_RD    = NUM_RD_DEF,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;

  regfile_clr_ctrl #(.DEPTH(DEPTH)) u_clr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_req (bus.clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]        rd_addr_a [NUM_RD];
  logic                     wr_fire;

  // Addresses that never hold data: holes past DEPTH, and entry 0 when hardwired.
  function automatic logic is_dead_addr(input logic [ADDR_W-1:0] a);
    return !regfile_addr_ok(32'(a), DEPTH) || (ZERO_REG0 && (a == '0));
  endfunction

  assign wr_fire = !busy && bus.reg_enable && bus.wr_en && !is_dead_addr(bus.wr_addr);

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // The sweep and client writes are mutually exclusive (wr_fire needs !busy).
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_idx] = '0;
    end else if (wr_fire) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Dead addresses still return rd_valid so the consumer is not stalled.
  always_comb begin
    rd_valid_d = '0;
    rd_data_d  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (!busy && bus.reg_enable && bus.rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        if (!is_dead_addr(rd_addr_a[p])) begin
`ifdef REGFILE_BYPASS_EN
          if (wr_fire && (bus.wr_addr == rd_addr_a[p])) begin
            rd_data_d[p*DATA_W +: DATA_W] = bus.wr_data;
          end else begin
            rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_a[p]];
          end
`else
          rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_a[p]];
`endif
        end
      end
    end
  end

  // NOTE: the storage is reset because reset must leave every entry at zero;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;

endmodule
